// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports and the memory-side bus of the data memory arbiter.
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              p0_req, p0_we, p0_ready, p0_rvalid, p0_err;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_ready, p1_rvalid, p1_err;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;
    logic              mem_read, mem_write;
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_read_data,
        output p0_ready, p0_rvalid, p0_rdata, p0_err, p1_ready, p1_rvalid, p1_rdata, p1_err,
        output mem_address, mem_write_data, mem_read, mem_write
    );
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_read_data,
        input  p0_ready, p0_rvalid, p0_rdata, p0_err, p1_ready, p1_rvalid, p1_rdata, p1_err,
        input  mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between two requesters, one registered access per two cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1000,
    parameter int FIXED_PRIO = 0
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state;
    logic              last_grant, port, we_q, oor;
    logic              gnt0, gnt1, sel_we, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, rsp_data;
    always_comb begin
        gnt1      = reset && state == IDLE && bus.p1_req && (!bus.p0_req || (FIXED_PRIO == 0 && !last_grant));
        gnt0      = reset && state == IDLE && bus.p0_req && !gnt1;
        sel_we    = gnt1 ? bus.p1_we : bus.p0_we;
        sel_addr  = gnt1 ? bus.p1_addr : bus.p0_addr;
        sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
        in_range  = sel_addr < ADDR_W'(DEPTH);
        rsp_data  = (we_q || oor) ? '0 : bus.mem_read_data;
    end
    assign bus.p0_ready = gnt0;
    assign bus.p1_ready = gnt1;
    // Out-of-range accesses hold the memory strobes low and only record the error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            port               <= 1'b0;
            we_q               <= 1'b0;
            oor                <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.p0_rvalid      <= 1'b0;
            bus.p0_err         <= 1'b0;
            bus.p0_rdata       <= '0;
            bus.p1_rvalid      <= 1'b0;
            bus.p1_err         <= 1'b0;
            bus.p1_rdata       <= '0;
        end else if (state == IDLE) begin
            bus.p0_rvalid <= 1'b0;
            bus.p1_rvalid <= 1'b0;
            if (gnt0 || gnt1) begin
                state              <= ACCESS;
                last_grant         <= gnt1;
                port               <= gnt1;
                we_q               <= sel_we;
                oor                <= !in_range;
                bus.mem_address    <= in_range ? sel_addr : '0;
                bus.mem_write_data <= in_range ? sel_wdata : '0;
                bus.mem_read       <= in_range && !sel_we;
                bus.mem_write      <= in_range && sel_we;
            end
        end else begin
            state              <= IDLE;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            if (port) begin
                bus.p1_rvalid <= 1'b1;
                bus.p1_rdata  <= rsp_data;
                bus.p1_err    <= oor;
            end else begin
                bus.p0_rvalid <= 1'b1;
                bus.p0_rdata  <= rsp_data;
                bus.p0_err    <= oor;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: transaction-level model of the arbiter checked every cycle, plus directed literal scenarios.
module tb_dmem_arbiter;
    localparam int DEPTH = 1000;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int fails = 0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_f ();
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .FIXED_PRIO(0)) dut (.clk(clk), .reset(reset), .bus(bus));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .FIXED_PRIO(1)) dut_f (.clk(clk), .reset(reset), .bus(bus_f));

    // Environment memory: words initialised to their own address, writes commit on the negedge.
    logic [31:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = i;
        forever begin
            @(negedge clk);
            if (bus.mem_write && bus.mem_address < DEPTH) mem[bus.mem_address[9:0]] = bus.mem_write_data;
        end
    end
    assign bus.mem_read_data   = (bus.mem_address < DEPTH) ? mem[bus.mem_address[9:0]] : 32'h0;
    assign bus_f.mem_read_data = bus_f.mem_address;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return (last == 1) ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    // Reference model: one in-flight transaction at a time, responses one edge after acceptance.
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_busy = 0, m_last = 1, m_port = 0;
    logic        m_we = 0, m_in;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [1:0]  e_rv = 0, e_err = 0;
    logic [31:0] e_rd [2];
    logic        e_mr = 0, e_mw = 0;
    logic [31:0] e_ma = 0, e_mwd = 0;
    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = i;
        e_rd[0] = 0;
        e_rd[1] = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 0; m_last = 1; e_rv = 0; e_err = 0; e_rd[0] = 0; e_rd[1] = 0;
                e_mr = 0; e_mw = 0; e_ma = 0; e_mwd = 0;
            end else if (m_busy != 0) begin
                m_in = m_addr < DEPTH;
                e_rv[m_port] = 1'b1;
                e_err[m_port] = !m_in;
                e_rd[m_port] = (m_in && !m_we) ? ref_mem[m_addr[9:0]] : 32'h0;
                if (m_in && m_we) ref_mem[m_addr[9:0]] = m_wdata;
                m_busy = 0; e_mr = 0; e_mw = 0; e_ma = 0; e_mwd = 0;
            end else begin
                int g;
                e_rv = 0;
                g = pick(bus.p0_req, bus.p1_req, m_last);
                if (g >= 0) begin
                    m_port = g; m_last = g; m_busy = 1;
                    m_we    = g == 1 ? bus.p1_we : bus.p0_we;
                    m_addr  = g == 1 ? bus.p1_addr : bus.p0_addr;
                    m_wdata = g == 1 ? bus.p1_wdata : bus.p0_wdata;
                    m_in  = m_addr < DEPTH;
                    e_ma  = m_in ? m_addr : 32'h0;
                    e_mwd = m_wdata;
                    e_mr  = m_in && !m_we;
                    e_mw  = m_in && m_we;
                end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = (reset && m_busy == 0) ? pick(bus.p0_req, bus.p1_req, m_last) : -1;
        chk("p0_ready", bus.p0_ready, g == 0);
        chk("p1_ready", bus.p1_ready, g == 1);
        chk("mem_read", bus.mem_read, e_mr);
        chk("mem_write", bus.mem_write, e_mw);
        chk("mem_address", bus.mem_address, e_ma);
        if (e_mw) chk("mem_write_data", bus.mem_write_data, e_mwd);
        chk("p0_rvalid", bus.p0_rvalid, e_rv[0]);
        chk("p1_rvalid", bus.p1_rvalid, e_rv[1]);
        chk("p0_rdata", bus.p0_rdata, e_rd[0]);
        chk("p1_rdata", bus.p1_rdata, e_rd[1]);
        if (e_rv[0]) chk("p0_err", bus.p0_err, e_err[0]);
        if (e_rv[1]) chk("p1_err", bus.p1_err, e_err[1]);
    end

    task automatic drive(input bit p, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    task automatic access(input bit p, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int lat, output logic mr, output logic mw);
        bit ok = 0;
        lat = 0; rd = 'x; err = 'x; mr = 'x; mw = 'x;
        @(posedge clk);
        #2 drive(p, 1'b1, we, addr, wdata);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p ? bus.p1_ready : bus.p0_ready) begin ok = 1; break; end
        end
        chk("grant_wait", ok, 1);
        @(posedge clk);
        #2 drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin mr = bus.mem_read; mw = bus.mem_write; end
            if (p ? bus.p1_rvalid : bus.p0_rvalid) begin
                lat = k;
                rd  = p ? bus.p1_rdata : bus.p0_rdata;
                err = p ? bus.p1_err : bus.p0_err;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, mr, mw, a0, a1;
        int          lat, cnt, seq[$];
        bit          ok;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        bus_f.p0_req = 0; bus_f.p0_we = 0; bus_f.p0_addr = 3; bus_f.p0_wdata = 0;
        bus_f.p1_req = 0; bus_f.p1_we = 0; bus_f.p1_addr = 4; bus_f.p1_wdata = 0;
        repeat (2) @(posedge clk);
        #2 bus.p0_req = 1;
        @(negedge clk);
        chk("reset_ready", bus.p0_ready, 0);
        chk("reset_mem_read", bus.mem_read, 0);
        chk("reset_rvalid", bus.p0_rvalid, 0);
        @(posedge clk);
        #2 begin bus.p0_req = 0; reset = 1; end

        access(0, 1, 5, 32'hDEADBEEF, rd, err, lat, mr, mw);
        chk("wr5_lat", lat, 2); chk("wr5_rdata", rd, 0); chk("wr5_err", err, 0);
        chk("wr5_mem_write", mw, 1); chk("wr5_mem_read", mr, 0);
        access(0, 0, 5, 0, rd, err, lat, mr, mw);
        chk("rd5_lat", lat, 2); chk("rd5_rdata", rd, 32'hDEADBEEF); chk("rd5_err", err, 0); chk("rd5_mem_read", mr, 1);

        access(1, 0, 999, 0, rd, err, lat, mr, mw);
        chk("rd999_rdata", rd, 999); chk("rd999_err", err, 0);
        access(1, 0, 1000, 0, rd, err, lat, mr, mw);
        chk("rd1000_lat", lat, 2); chk("rd1000_rdata", rd, 0); chk("rd1000_err", err, 1);
        chk("rd1000_mem_read", mr, 0); chk("rd1000_mem_write", mw, 0);

        @(posedge clk);
        #2 begin drive(0, 1, 0, 10, 0); drive(1, 1, 0, 20, 0); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.p0_ready) seq.push_back(0);
            if (bus.p1_ready) seq.push_back(1);
            if (bus.p0_rvalid) chk("alt_p0_rdata", bus.p0_rdata, 10);
            if (bus.p1_rvalid) chk("alt_p1_rdata", bus.p1_rdata, 20);
        end
        @(posedge clk);
        #2 begin drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); end
        chk("alt_count", seq.size(), 8);
        if (seq.size() > 0) chk("alt_first", seq[0], 0);
        for (int i = 1; i < seq.size(); i++) chk("alt_switch", seq[i] != seq[i-1], 1);
        repeat (3) @(posedge clk);

        #2 begin bus_f.p0_req = 1; bus_f.p1_req = 1; end
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("fixed_p1_blocked", bus_f.p1_ready, 0);
            if (bus_f.p0_ready) cnt++;
            if (bus_f.p0_rvalid) chk("fixed_p0_rdata", bus_f.p0_rdata, 3);
        end
        chk("fixed_p0_grants", cnt, 5);
        @(posedge clk);
        #2 bus_f.p0_req = 0;
        @(negedge clk);
        chk("fixed_p1_after_drop", bus_f.p1_ready, 1);
        @(posedge clk);
        #2 bus_f.p1_req = 0;
        repeat (3) @(posedge clk);

        #2 drive(0, 1, 1, 7, 32'h12345678);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.p0_ready) begin ok = 1; break; end
        end
        chk("rst_grant_wait", ok, 1);
        @(posedge clk);
        #2 begin drive(0, 0, 0, 0, 0); reset = 0; end
        #1 chk("rst_mem_write_drop", bus.mem_write, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_rvalid", bus.p0_rvalid, 0);
        end
        chk("rst_mem7_kept", mem[7], 7);
        @(posedge clk);
        #2 begin reset = 1; drive(0, 1, 0, 1, 0); drive(1, 1, 0, 2, 0); end
        @(negedge clk);
        chk("rst_p0_wins", bus.p0_ready, 1);
        chk("rst_p1_waits", bus.p1_ready, 0);
        @(posedge clk);
        #2 drive(0, 0, 0, 0, 0);

        a0 = 0; a1 = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = bus.p0_req && bus.p0_ready;
            a1 = bus.p1_req && bus.p1_ready;
            @(posedge clk);
            #2;
            for (int p = 0; p < 2; p++) begin
                logic req, acc;
                logic [31:0] addr;
                req = p == 1 ? bus.p1_req : bus.p0_req;
                acc = p == 1 ? a1 : a0;
                addr = ($urandom_range(0, 7) == 0) ? $urandom_range(990, 1010) :
                       ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(0, 63);
                if (!req || acc) drive(p[0], $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, addr, $urandom);
                else if ($urandom_range(0, 15) == 0) drive(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
